pc_stack_unit: RTL and testbench

//  Program-counter and return-stack stage that feeds the instruction memory address (13-bit, 8K words).

---
 rtl/pc_stack_unit.sv | 152 +++++++++++++++
 tb/tb_pc_stack_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter and 8-level circular return stack for the instruction fetch stage.
// Resolves inc/goto/call/return once per instruction cycle and marks the jump-shadow word.
module pc_stack_unit #(
    parameter int PC_W      = 13,
    parameter int JMP_W     = 11,
    parameter int DEPTH     = 8,
    parameter int RESET_VEC = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       adv,
    input  logic [1:0]                 op,
    input  logic [JMP_W-1:0]           target,
    input  logic [PC_W-JMP_W-1:0]      page,
    output logic [PC_W-1:0]            pc_out,
    output logic [$clog2(DEPTH)-1:0]   sp,
    output logic                       flush,
    output logic                       stk_ovf,
    output logic                       stk_unf
);

    localparam int SP_W = $clog2(DEPTH);
    localparam logic [SP_W:0]   CNT_FULL = (SP_W+1)'(DEPTH);
    localparam logic [SP_W:0]   CNT_ZERO = '0;
    localparam logic [PC_W-1:0] PC_RST   = PC_W'(RESET_VEC);

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_GOTO = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    logic [PC_W-1:0] r_pc;
    logic [SP_W-1:0] r_sp;
    logic [SP_W:0]   r_cnt;
    logic            r_flush;
    logic            r_ovf;
    logic            r_unf;

    logic [PC_W-1:0] r_pc_next;
    logic [SP_W-1:0] r_sp_next;
    logic [SP_W:0]   r_cnt_next;
    logic            r_flush_next;
    logic            r_ovf_next;
    logic            r_unf_next;

    op_e             w_op;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_dest;
    logic [SP_W-1:0] w_sp_inc;
    logic [SP_W-1:0] w_sp_dec;
    logic [PC_W-1:0] w_top;
    logic            w_push;
    logic [PC_W-1:0] w_stack [DEPTH];

    assign w_op     = op_e'(op);
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_dest   = {page, target};
    assign w_sp_inc = r_sp + SP_W'(1);
    assign w_sp_dec = r_sp - SP_W'(1);
    assign w_top    = w_stack[w_sp_dec];

    // Next-state decode; a pending flush forces the cycle to behave as a plain increment.
    always_comb begin
        r_pc_next    = r_pc;
        r_sp_next    = r_sp;
        r_cnt_next   = r_cnt;
        r_flush_next = r_flush;
        r_ovf_next   = r_ovf;
        r_unf_next   = r_unf;
        w_push       = 1'b0;
        if (adv) begin
            if (r_flush || (w_op == OP_INC)) begin
                r_pc_next    = w_pc_inc;
                r_flush_next = 1'b0;
            end else begin
                case (w_op)
                    OP_GOTO: begin
                        r_pc_next    = w_dest;
                        r_flush_next = 1'b1;
                    end
                    OP_CALL: begin
                        w_push       = 1'b1;
                        r_sp_next    = w_sp_inc;
                        r_pc_next    = w_dest;
                        r_flush_next = 1'b1;
                        if (r_cnt == CNT_FULL) begin
                            r_ovf_next = 1'b1;
                        end else begin
                            r_cnt_next = r_cnt + (SP_W+1)'(1);
                        end
                    end
                    OP_RET: begin
                        r_sp_next    = w_sp_dec;
                        r_pc_next    = w_top;
                        r_flush_next = 1'b1;
                        if (r_cnt == CNT_ZERO) begin
                            r_unf_next = 1'b1;
                        end else begin
                            r_cnt_next = r_cnt - (SP_W+1)'(1);
                        end
                    end
                    default: begin
                        r_pc_next    = w_pc_inc;
                        r_flush_next = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= PC_RST;
            r_sp    <= '0;
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= r_pc_next;
            r_sp    <= r_sp_next;
            r_cnt   <= r_cnt_next;
            r_flush <= r_flush_next;
            r_ovf   <= r_ovf_next;
            r_unf   <= r_unf_next;
        end
    end

    // Entries live in flops rather than RAM because reset must clear every slot.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [PC_W-1:0] r_entry;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_entry <= '0;
                end else if (w_push && (r_sp == SP_W'(gi))) begin
                    r_entry <= w_pc_inc;
                end
            end
            assign w_stack[gi] = r_entry;
        end
    endgenerate

    assign pc_out  = r_pc;
    assign sp      = r_sp;
    assign flush   = r_flush;
    assign stk_ovf = r_ovf;
    assign stk_unf = r_unf;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: each adv cycle queues the expected state, checked one edge later.
module tb_pc_stack_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        adv;
    logic [1:0]  op;
    logic [10:0] target;
    logic [1:0]  page;
    logic [12:0] pc_out;
    logic [2:0]  sp;
    logic        flush;
    logic        stk_ovf;
    logic        stk_unf;

    pc_stack_unit dut (
        .clk     (clk),
        .reset   (reset),
        .adv     (adv),
        .op      (op),
        .target  (target),
        .page    (page),
        .pc_out  (pc_out),
        .sp      (sp),
        .flush   (flush),
        .stk_ovf (stk_ovf),
        .stk_unf (stk_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] pc;
        logic [2:0]  sp;
        logic        flush;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [12:0] m_pc;
    int          m_sp;
    int          m_cnt;
    logic        m_flush;
    logic        m_ovf;
    logic        m_unf;
    logic [12:0] m_stack [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 13'h0; m_sp = 0; m_cnt = 0;
        m_flush = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        for (int i = 0; i < 8; i++) m_stack[i] = 13'h0;
    endtask

    task automatic check_state(input string tag, input exp_t e);
        check({tag, ".pc"},    32'(pc_out),  32'(e.pc));
        check({tag, ".sp"},    32'(sp),      32'(e.sp));
        check({tag, ".flush"}, 32'(flush),   32'(e.flush));
        check({tag, ".ovf"},   32'(stk_ovf), 32'(e.ovf));
        check({tag, ".unf"},   32'(stk_unf), 32'(e.unf));
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.pc = m_pc; e.sp = 3'(m_sp); e.flush = m_flush; e.ovf = m_ovf; e.unf = m_unf;
        return e;
    endfunction

    // Called #1 after a rising edge; drives one cycle and checks the result #1 after the next edge.
    task automatic step(input logic a, input logic [1:0] o, input logic [1:0] pg,
                        input logic [10:0] tg, input string tag);
        exp_t e;
        adv = a; op = o; page = pg; target = tg;
        if (a) begin
            if (m_flush || o == 2'b00) begin
                m_pc = m_pc + 13'h1;
                m_flush = 1'b0;
            end else if (o == 2'b01) begin
                m_pc = {pg, tg};
                m_flush = 1'b1;
            end else if (o == 2'b10) begin
                m_stack[m_sp] = m_pc + 13'h1;
                m_sp = (m_sp + 1) % 8;
                if (m_cnt == 8) m_ovf = 1'b1; else m_cnt++;
                m_pc = {pg, tg};
                m_flush = 1'b1;
            end else begin
                m_sp = (m_sp + 7) % 8;
                m_pc = m_stack[m_sp];
                if (m_cnt == 0) m_unf = 1'b1; else m_cnt--;
                m_flush = 1'b1;
            end
        end
        sb_q.push_back(model_snapshot());
        @(posedge clk);
        #1;
        adv = 1'b0;
        e = sb_q.pop_front();
        $display("txn %s adv=%0b op=%0d dest=%h -> pc=%h sp=%0d flush=%0b ovf=%0b unf=%0b",
                 tag, a, o, {pg, tg}, pc_out, sp, flush, stk_ovf, stk_unf);
        check_state(tag, e);
    endtask

    // Asserted #1 after an edge; outputs must clear before the following edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        check_state(tag, model_snapshot());
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("txn %s reset released pc=%h sp=%0d", tag, pc_out, sp);
        check_state({tag, "_rel"}, model_snapshot());
    endtask

    initial begin
        reset = 1'b0; adv = 1'b0; op = 2'b00; page = 2'b00; target = 11'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_state("por", model_snapshot());

        // Run a little, then reset mid-stream while a call shadow is pending.
        step(1'b1, 2'b01, 2'b00, 11'h123, "t1_goto");
        step(1'b1, 2'b00, 2'b00, 11'h000, "t1_inc");
        step(1'b1, 2'b10, 2'b01, 11'h050, "t1_call");
        do_reset("t1_rst");
        for (int i = 0; i < 3; i++) step(1'b0, 2'($urandom_range(0, 3)), 2'b11, 11'h7FF, "t1_hold");

        // Return from an empty stack: circular pop of cleared entry 7.
        step(1'b1, 2'b11, 2'b00, 11'h000, "t5_ret_empty");
        step(1'b1, 2'b00, 2'b00, 11'h000, "t5_shadow");
        do_reset("t5_rst");

        // Page/target concatenation and PC wrap at 1FFF.
        step(1'b1, 2'b01, 2'b11, 11'h7FE, "t2_goto");
        step(1'b1, 2'b00, 2'b00, 11'h000, "t2_inc1");
        step(1'b0, 2'b01, 2'b00, 11'h000, "t2_hold");
        step(1'b1, 2'b00, 2'b00, 11'h000, "t2_inc2");
        step(1'b1, 2'b00, 2'b00, 11'h000, "t2_wrap");

        // Call, ignored goto in the shadow, return to call site + 1.
        step(1'b1, 2'b01, 2'b00, 11'h00F, "t3_goto");
        step(1'b1, 2'b00, 2'b00, 11'h000, "t3_to010");
        step(1'b1, 2'b10, 2'b00, 11'h100, "t3_call");
        step(1'b1, 2'b01, 2'b00, 11'h555, "t3_ign_goto");
        step(1'b1, 2'b11, 2'b00, 11'h000, "t3_ret");
        step(1'b1, 2'b00, 2'b00, 11'h000, "t3_shadow");
        do_reset("t3_rst");

        // Nine nested calls overflow the stack; eight returns unwind it.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 2'b10, 2'b00, 11'(11'h200 + i), $sformatf("t4_call%0d", i));
            step(1'b1, 2'b00, 2'b00, 11'h000, "t4_shadow");
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'b11, 2'b00, 11'h000, $sformatf("t4_ret%0d", i));
            step(1'b1, 2'b00, 2'b00, 11'h000, "t4_shadow");
        end

        // Random mix, then reset right after a call edge.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 11'($urandom_range(0, 2047)), "rnd");
        end
        step(1'b1, 2'b00, 2'b00, 11'h000, "t6_pre");
        if (m_flush) step(1'b1, 2'b00, 2'b00, 11'h000, "t6_pre2");
        step(1'b1, 2'b10, 2'b00, 11'h300, "t6_call");
        do_reset("t6_rst");
        step(1'b1, 2'b10, 2'b01, 11'h300, "t6_first_adv");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
